mem_cmd_responder: RTL and testbench

Memory-side responder for the CPU controller's `mem_cmd`/`mem_addr`/`write_data` bus. It decodes the per-cycle command and serves reads and writes to an internal word RAM. It also serves two memory-mapped I/O locations: an LED output register and a switch input port. The block sits between the controller/datapath and the board I/O, and supplies `read_data` back to the datapath's memory-data path.

---
 rtl/mem_cmd_responder.sv | 121 ++++++++++++
 tb/tb_mem_cmd_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_responder.sv
// Memory-side responder for the CPU mem_cmd bus: word RAM plus LED register and switch port.
// Optional access counters are enabled with `define MEM_STATS_EN.
module mem_cmd_responder #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RAM_WORDS = 256,
  parameter int unsigned LED_ADDR  = 'h100,
  parameter int unsigned SW_ADDR   = 'h140
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out,
  output logic              bus_err
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  logic [DATA_W-1:0] ram [RAM_WORDS];

  cmd_e              cmd;
  logic              hit_ram;
  logic              hit_led;
  logic              hit_sw;
  logic [RAM_AW-1:0] ram_idx;
  logic              rd_ok;
  logic              wr_ok;
  logic              err_c;
  logic [DATA_W-1:0] rd_mux;
  logic [7:0]        sw_meta;
  logic [7:0]        sw_sync;

  // Address decode; the RAM index is only used once the range check has passed.
  always_comb begin
    cmd     = cmd_e'(mem_cmd);
    hit_ram = ({1'b0, mem_addr} < (ADDR_W + 1)'(RAM_WORDS));
    hit_led = (mem_addr == ADDR_W'(LED_ADDR));
    hit_sw  = (mem_addr == ADDR_W'(SW_ADDR));
    ram_idx = mem_addr[RAM_AW-1:0];
    rd_ok   = hit_ram | hit_led | hit_sw;
    wr_ok   = hit_ram | hit_led;
    rd_mux  = '0;
    if (hit_ram) begin
      rd_mux = ram[ram_idx];
    end else if (hit_sw) begin
      rd_mux = DATA_W'(sw_sync);
    end else if (hit_led) begin
      rd_mux = DATA_W'(led_out);
    end
    err_c = ((cmd == CMD_READ) && !rd_ok) ||
            ((cmd == CMD_WRITE) && !wr_ok) ||
            (cmd == CMD_RSVD);
  end

  // Registered read path, LED register, switch synchronizer and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
      rd_valid  <= 1'b0;
      led_out   <= '0;
      bus_err   <= 1'b0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      sw_meta  <= sw_in;
      sw_sync  <= sw_meta;
      rd_valid <= (cmd == CMD_READ);
      if (cmd == CMD_READ) begin
        read_data <= rd_mux;
      end
      if ((cmd == CMD_WRITE) && hit_led) begin
        led_out <= write_data[7:0];
      end
      if (err_c) begin
        bus_err <= 1'b1;
      end
    end
  end

  // RAM array is never cleared; commands during reset are ignored.
  always_ff @(posedge clk) begin
    if (!rst && (cmd == CMD_WRITE) && hit_ram) begin
      ram[ram_idx] <= write_data;
    end
  end

`ifdef MEM_STATS_EN
  // Saturating counters of accepted (legal) accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if ((cmd == CMD_READ) && rd_ok && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
      if ((cmd == CMD_WRITE) && wr_ok && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_cmd_responder.sv
// Scoreboard bench for mem_cmd_responder: driver queues per-cycle expectations, monitor checks them.
module tb_mem_cmd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        rd_valid;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;
  logic        bus_err;
`ifdef MEM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  mem_cmd_responder dut (
    .clk        (clk),
    .rst        (rst),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .rd_valid   (rd_valid),
    .sw_in      (sw_in),
    .led_out    (led_out),
    .bus_err    (bus_err)
`ifdef MEM_STATS_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        chk_d;
    logic [15:0] d;
    logic [7:0]  led;
    logic        err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_led = 8'h00;
  logic       exp_err = 1'b0;

  function automatic void check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endfunction

  // Monitor: one expectation per sampled edge, compared on the following negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("rd_valid", 16'(rd_valid), 16'(e.v));
      if (e.chk_d) check("read_data", read_data, e.d);
      check("led_out", 16'(led_out), 16'(e.led));
      check("bus_err", 16'(bus_err), 16'(e.err));
    end
  end

  task automatic cyc(input logic r, input logic [1:0] c, input logic [8:0] a,
                     input logic [15:0] wd, input logic v, input logic cd, input logic [15:0] d);
    rst = r; mem_cmd = c; mem_addr = a; write_data = wd;
    @(posedge clk);
    q.push_back('{v: v, chk_d: cd, d: d, led: exp_led, err: exp_err});
    #1;
  endtask

  task automatic do_reset();
    exp_led = 8'h00; exp_err = 1'b0;
    cyc(1'b1, 2'b00, 9'h000, 16'h0000, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic rd(input logic [8:0] a, input logic [15:0] d);
    cyc(1'b0, 2'b01, a, 16'h0000, 1'b1, 1'b1, d);
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] wd);
    cyc(1'b0, 2'b10, a, wd, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 9'h000, 16'h0000, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; mem_cmd = 2'b00; mem_addr = '0; write_data = '0; sw_in = 8'h00;
    do_reset();
    do_reset();

    // RAM write/read, rd_valid drops after return to idle, read_data holds
    wr(9'h005, 16'hBEEF);
    rd(9'h005, 16'hBEEF);
    cyc(1'b0, 2'b00, 9'h000, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
    wr(9'h0FF, 16'h1234);
    rd(9'h0FF, 16'h1234);
    wr(9'h000, 16'h0001);
    rd(9'h000, 16'h0001);
    rd(9'h005, 16'hBEEF);
    rd(9'h005, 16'hBEEF);
    rd(9'h0FF, 16'h1234);
    idle();

    // LED register
    exp_led = 8'hA5;
    wr(9'h100, 16'h12A5);
    rd(9'h100, 16'h00A5);

    // Switch synchronizer: two edges before a read sees a change
    sw_in = 8'h3C;
    idle();
    idle();
    rd(9'h140, 16'h003C);
    sw_in = 8'h81;
    rd(9'h140, 16'h003C);
    rd(9'h140, 16'h003C);
    rd(9'h140, 16'h0081);

    // Illegal accesses set sticky bus_err
    exp_err = 1'b1;
    rd(9'h1F0, 16'h0000);
    wr(9'h140, 16'hFFFF);
    rd(9'h140, 16'h0081);
    idle();
    wr(9'h101, 16'h00FF);
    rd(9'h100, 16'h00A5);

    // Reset with a write pending: write ignored, RAM retained, err/led cleared
    exp_led = 8'h00; exp_err = 1'b0;
    cyc(1'b1, 2'b10, 9'h005, 16'h1111, 1'b0, 1'b1, 16'h0000);
    rd(9'h005, 16'hBEEF);
    rd(9'h100, 16'h0000);

    // Reserved command: no access, rd_valid stays low, error set
    exp_err = 1'b1;
    cyc(1'b0, 2'b11, 9'h005, 16'h2222, 1'b0, 1'b1, 16'h0000);
    rd(9'h005, 16'hBEEF);

    // Boundary just past RAM and below SW port
    do_reset();
    rd(9'h0FF, 16'h1234);
    exp_err = 1'b1;
    rd(9'h13F, 16'h0000);

`ifdef MEM_STATS_EN
    do_reset();
    rd(9'h005, 16'hBEEF);
    wr(9'h010, 16'hAAAA);
    rd(9'h010, 16'hAAAA);
    wr(9'h011, 16'h5555);
    exp_err = 1'b1;
    wr(9'h1FF, 16'h0BAD);
    rd(9'h011, 16'h5555);
    check("rd_count", rd_count, 16'd3);
    check("wr_count", wr_count, 16'd2);
    exp_err = 1'b0;
    cyc(1'b1, 2'b10, 9'h010, 16'h7777, 1'b0, 1'b1, 16'h0000);
    check("rd_count_rst", rd_count, 16'd0);
    check("wr_count_rst", wr_count, 16'd0);
    rd(9'h010, 16'hAAAA);
    check("rd_count_after", rd_count, 16'd1);
`endif

    idle();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
